// File: rtl/pc_unit_pkg.sv
// cpu_defs: shared definitions for the single-cycle MIPS datapath.
//   WORD_W      - datapath word width
//   word_t      - one datapath word
//   pc_sel_e    - decoder next-PC select encodings
//   pc_state_e  - pc_unit control state
//   sat_inc()   - saturating word increment (used by the retired counter)
package cpu_defs;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_JUMP = 2'b01,
        PC_JR   = 2'b10,
        PC_RSVD = 2'b11
    } pc_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_HALT  = 2'b01,
        ST_FAULT = 2'b10
    } pc_state_e;

    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: decoder/datapath <-> program-counter bus.
//   Controls (master -> slave): pc_next, beq, bne, zero, imm16, jaddr,
//                               rs_val, stall
//   Status   (slave -> master): pc, pc_plus4, halted, fault, retired
// The master side is the decoder/datapath; pc_unit uses the slave modport.
interface pc_unit_if;
    import cpu_defs::*;

    logic [1:0]  pc_next;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    word_t       rs_val;
    logic        stall;

    word_t       pc;
    word_t       pc_plus4;
    logic        halted;
    logic        fault;
    word_t       retired;

    modport master (
        output pc_next, beq, bne, zero, imm16, jaddr, rs_val, stall,
        input  pc, pc_plus4, halted, fault, retired
    );

    modport slave (
        input  pc_next, beq, bne, zero, imm16, jaddr, rs_val, stall,
        output pc, pc_plus4, halted, fault, retired
    );

endinterface

// File: rtl/pc_unit_next_pc_calc.sv
// next_pc_calc: purely combinational next-PC computation.
//   pc         in  - current PC
//   pc_next    in  - next-PC select (cpu_defs::pc_sel_e encoding)
//   beq/bne    in  - branch type
//   zero       in  - ALU zero flag
//   imm16      in  - branch displacement (words, signed)
//   jaddr      in  - jump target field
//   rs_val     in  - jr target
//   pc_plus4   out - pc + 4 (wraps modulo 2^32)
//   target     out - selected next PC
//   misaligned out - jr target is not word aligned
module next_pc_calc
    import cpu_defs::*;
(
    input  word_t       pc,
    input  logic [1:0]  pc_next,
    input  logic        beq,
    input  logic        bne,
    input  logic        zero,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr,
    input  word_t       rs_val,
    output word_t       pc_plus4,
    output word_t       target,
    output logic        misaligned
);

    word_t br_off;
    logic  taken;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    // beq and bne together is a malformed decode: treat as not taken
    // rather than letting the OR of the two conditions always fire.
    assign taken = (pc_next == PC_SEQ) && !(beq && bne) &&
                   ((beq && zero) || (bne && !zero));

    assign misaligned = (pc_next == PC_JR) && (rs_val[1:0] != 2'b00);

    always_comb begin
        target = pc_plus4;
        case (pc_sel_e'(pc_next))
            PC_SEQ:  target = taken ? (pc_plus4 + br_off) : pc_plus4;
            PC_JUMP: target = {pc_plus4[31:28], jaddr, 2'b00};
            PC_JR:   target = rs_val;
            PC_RSVD: target = pc_plus4;
            default: target = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage of the single-cycle MIPS datapath.
//   RESET_PC  param - PC loaded on reset (word aligned)
//   clk       in    - system clock, rising edge
//   reset     in    - synchronous, active-high
//   bus       slave - controls in; pc, pc_plus4, halted, fault, retired out
// Holds the PC register, the RUN/HALT/FAULT state machine and the
// saturating retired-instruction counter. HALT and FAULT are terminal
// until reset.
module pc_unit
    import cpu_defs::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.slave   bus
);

    pc_state_e state;
    word_t     pc_q;
    word_t     retired_q;
    logic      halted_q;
    logic      fault_q;

    word_t     pc_plus4;
    word_t     target;
    logic      misaligned;

    next_pc_calc u_calc (
        .pc         (pc_q),
        .pc_next    (bus.pc_next),
        .beq        (bus.beq),
        .bne        (bus.bne),
        .zero       (bus.zero),
        .imm16      (bus.imm16),
        .jaddr      (bus.jaddr),
        .rs_val     (bus.rs_val),
        .pc_plus4   (pc_plus4),
        .target     (target),
        .misaligned (misaligned)
    );

    // Fault check outranks halt check: a misaligned jr to itself faults.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_RUN;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            halted_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (misaligned) begin
                            state   <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else if (target == pc_q) begin
                            state     <= ST_HALT;
                            halted_q  <= 1'b1;
                            retired_q <= sat_inc(retired_q);
                        end else begin
                            pc_q      <= target;
                            retired_q <= sat_inc(retired_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.halted   = halted_q;
    assign bus.fault    = fault_q;
    assign bus.retired  = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit. Stimulus pushes hand-computed
// expectations into queues; a negedge monitor pops and compares.
// dut0 uses RESET_PC=0, dut1 uses RESET_PC=0xFFFF_FFFC (wrap case).
module tb_pc_unit;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pc_unit_if bus0();
    pc_unit_if bus1();

    pc_unit #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus0)
    );

    pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus1)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] plus4;
        logic [31:0] retired;
        logic        halted;
        logic        fault;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    int   errors = 0;
    int   checks = 0;

    task automatic compare(input string tag, input exp_t e,
                           input logic [31:0] pc, input logic [31:0] plus4,
                           input logic [31:0] ret, input logic h, input logic f);
        checks++;
        if ({pc, plus4, ret, h, f} !== {e.pc, e.plus4, e.retired, e.halted, e.fault}) begin
            errors++;
            $display("FAIL %s/%s: got pc=%h plus4=%h retired=%0d halted=%b fault=%b, want pc=%h plus4=%h retired=%0d halted=%b fault=%b",
                     tag, e.name, pc, plus4, ret, h, f,
                     e.pc, e.plus4, e.retired, e.halted, e.fault);
        end
    endtask

    // Monitor: one expectation per queued edge, checked mid-cycle.
    always @(negedge clk) begin
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            compare("dut0", e0, bus0.pc, bus0.pc_plus4, bus0.retired, bus0.halted, bus0.fault);
        end
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            compare("dut1", e1, bus1.pc, bus1.pc_plus4, bus1.retired, bus1.halted, bus1.fault);
        end
    end

    function automatic exp_t mk(input string name, input logic [31:0] pc,
                                input logic [31:0] ret, input logic h, input logic f);
        exp_t e;
        e.name    = name;
        e.pc      = pc;
        e.plus4   = pc + 32'd4;
        e.retired = ret;
        e.halted  = h;
        e.fault   = f;
        return e;
    endfunction

    // Drive dut0 controls, take one edge, queue the expected post-edge state.
    task automatic step(input string name, input logic r, input logic st,
                        input logic [1:0] pn, input logic bq, input logic bn,
                        input logic z, input logic [15:0] imm,
                        input logic [25:0] ja, input logic [31:0] rs,
                        input logic [31:0] epc, input logic [31:0] eret,
                        input logic eh, input logic ef);
        rst          = r;
        bus0.stall   = st;
        bus0.pc_next = pn;
        bus0.beq     = bq;
        bus0.bne     = bn;
        bus0.zero    = z;
        bus0.imm16   = imm;
        bus0.jaddr   = ja;
        bus0.rs_val  = rs;
        @(posedge clk);
        q0.push_back(mk(name, epc, eret, eh, ef));
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        bus1.stall   = 1'b1;
        bus1.pc_next = 2'b00;
        bus1.beq     = 1'b0;
        bus1.bne     = 1'b0;
        bus1.zero    = 1'b0;
        bus1.imm16   = '0;
        bus1.jaddr   = '0;
        bus1.rs_val  = '0;

        //    name         rst st  pn     bq bn z  imm       jaddr      rs_val         pc             ret    h  f
        step("reset",      1, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h0,         32'd0,  0, 0);
        q1.push_back(mk("reset", 32'hFFFF_FFFC, 32'd0, 1'b0, 1'b0));
        step("seq1",       0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h4,         32'd1,  0, 0);
        step("seq2",       0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h8,         32'd2,  0, 0);
        step("seq3",       0, 0, 2'b00, 1, 0, 0, 16'h7,    26'h0,     32'h0,         32'hC,         32'd3,  0, 0);
        step("seq4",       0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h10,        32'd4,  0, 0);
        step("beq_taken",  0, 0, 2'b00, 1, 0, 1, 16'hFFFE, 26'h0,     32'h0,         32'hC,         32'd5,  0, 0);
        step("beq_not",    0, 0, 2'b00, 1, 0, 0, 16'hFFFE, 26'h0,     32'h0,         32'h10,        32'd6,  0, 0);
        step("bne_taken",  0, 0, 2'b00, 0, 1, 0, 16'h0003, 26'h0,     32'h0,         32'h20,        32'd7,  0, 0);
        step("rsvd_sel",   0, 0, 2'b11, 1, 0, 1, 16'h0010, 26'h3FF,   32'h0,         32'h24,        32'd8,  0, 0);
        step("jr_high",    0, 0, 2'b10, 0, 0, 0, 16'h0,    26'h0,     32'h4000_0000, 32'h4000_0000, 32'd9,  0, 0);
        step("jump",       0, 0, 2'b01, 0, 0, 0, 16'h0,    26'h100,   32'h0,         32'h4000_0400, 32'd10, 0, 0);
        step("jr_80",      0, 0, 2'b10, 0, 0, 0, 16'h0,    26'h0,     32'h80,        32'h80,        32'd11, 0, 0);
        step("jr_mis",     0, 0, 2'b10, 0, 0, 0, 16'h0,    26'h0,     32'h82,        32'h80,        32'd11, 0, 1);
        step("fault_frz1", 0, 0, 2'b01, 0, 0, 0, 16'h0,    26'h5,     32'h0,         32'h80,        32'd11, 0, 1);
        step("fault_frz2", 0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h80,        32'd11, 0, 1);
        step("reset2",     1, 1, 2'b01, 0, 0, 0, 16'h0,    26'h9,     32'h0,         32'h0,         32'd0,  0, 0);
        step("beq_bne",    0, 0, 2'b00, 1, 1, 1, 16'h0005, 26'h0,     32'h0,         32'h4,         32'd1,  0, 0);
        step("stall1",     0, 1, 2'b01, 0, 0, 0, 16'h0,    26'h9,     32'h0,         32'h4,         32'd1,  0, 0);
        step("stall2",     0, 1, 2'b01, 0, 0, 0, 16'h0,    26'h9,     32'h0,         32'h4,         32'd1,  0, 0);
        step("release",    0, 0, 2'b01, 0, 0, 0, 16'h0,    26'h9,     32'h0,         32'h24,        32'd2,  0, 0);
        step("halt",       0, 0, 2'b00, 1, 0, 1, 16'hFFFF, 26'h0,     32'h0,         32'h24,        32'd3,  1, 0);
        step("halt_frz1",  0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h24,        32'd3,  1, 0);
        step("halt_frz2",  0, 0, 2'b10, 0, 0, 0, 16'h0,    26'h0,     32'h82,        32'h24,        32'd3,  1, 0);
        step("halt_frz3",  0, 0, 2'b01, 0, 0, 0, 16'h0,    26'h3F,    32'h0,         32'h24,        32'd3,  1, 0);
        step("halt_frz4",  0, 0, 2'b00, 0, 1, 0, 16'h0040, 26'h0,     32'h0,         32'h24,        32'd3,  1, 0);
        bus1.stall = 1'b0;
        step("halt_frz5",  0, 0, 2'b10, 0, 0, 0, 16'h0,    26'h0,     32'h100,       32'h24,        32'd3,  1, 0);
        q1.push_back(mk("wrap", 32'h0, 32'd1, 1'b0, 1'b0));
        bus1.stall = 1'b1;
        step("reset_halt", 1, 0, 2'b00, 1, 0, 1, 16'hFFFF, 26'h0,     32'h0,         32'h0,         32'd0,  0, 0);
        step("post_reset", 0, 0, 2'b00, 0, 0, 0, 16'h0,    26'h0,     32'h0,         32'h4,         32'd1,  0, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d/%0d pending expectations, want 0/0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
